// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and state encoding for the program-counter sequencer.
package pc_sequencer_pkg;

   localparam int unsigned PcsXlen      = 64;
   localparam int unsigned PcsImemDepth = 1024;
   localparam logic [63:0] PcsResetPc   = 64'h0;

   // Sequencer state; encodings are visible on the state output.
   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StHalt  = 2'b10,
      StFault = 2'b11
   } pcs_state_e;

endpackage

// File: rtl/pc_addr_check.sv
// Combinational fetch-address check: word aligned and inside instruction memory.
module pc_addr_check #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned IMEM_DEPTH = 1024
) (
   input  logic [XLEN-1:0] addr,
   output logic            valid
);

   localparam logic [XLEN-1:0] LastWord = XLEN'(IMEM_DEPTH - 1);

   logic [XLEN-1:0] word_idx;

   // Full-width word index so high address bits can never alias into range.
   assign word_idx = {2'b00, addr[XLEN-1:2]};
   assign valid    = (addr[1:0] == 2'b00) && (word_idx <= LastWord);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the single-issue core.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned     XLEN       = PcsXlen,
   parameter int unsigned     IMEM_DEPTH = PcsImemDepth,
   parameter logic [XLEN-1:0] RESET_PC   = PcsResetPc[XLEN-1:0]
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req,
   output logic [XLEN-1:0] pc,
   output logic [9:0]      imem_addr,
   output logic            fetch_valid,
   output logic            flush,
   output logic            inv_addr,
   output logic [1:0]      state,
   output logic [31:0]     fetch_count
);

   pcs_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            flush_q, flush_d;
   logic            inv_q, inv_d;
   logic [31:0]     fetch_count_q;
   logic [XLEN-1:0] cand_pc;
   logic            cand_ok;

   // Redirect target beats the sequential successor as the candidate next PC.
   assign cand_pc = redirect_valid ? redirect_pc : pc_q + XLEN'(4);

   pc_addr_check #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_addr_check (
      .addr  (cand_pc),
      .valid (cand_ok)
   );

   // Next-state logic: halt > redirect > stall > sequential while running.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      inv_d   = inv_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (halt_req) begin
               state_d = StHalt;
            end else if (redirect_valid || !stall) begin
               pc_d    = cand_pc;
               flush_d = redirect_valid;
               if (!cand_ok) begin
                  // Park on the offending address so software can see it.
                  state_d = StFault;
                  inv_d   = 1'b1;
                  flush_d = 1'b1;
               end
            end
         end
         StHalt:  ;
         StFault: ;
      endcase
   end

   // State, PC, flush and sticky fault registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         flush_q <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         inv_q   <= inv_d;
      end
   end

   // Saturating count of cycles that issued a fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= 32'h0;
      end else if (fetch_valid && (fetch_count_q != 32'hFFFF_FFFF)) begin
         fetch_count_q <= fetch_count_q + 32'h1;
      end
   end

   assign fetch_valid = (state_q == StRun) && !stall;
   assign imem_addr   = pc_q[11:2];
   assign pc          = pc_q;
   assign flush       = flush_q;
   assign inv_addr    = inv_q;
   assign state       = state_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt_req;
   logic [63:0] pc;
   logic [9:0]  imem_addr;
   logic        fetch_valid;
   logic        flush;
   logic        inv_addr;
   logic [1:0]  state;
   logic [31:0] fetch_count;

   int n_checks;
   int n_fail;

   pc_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .pc             (pc),
      .imem_addr      (imem_addr),
      .fetch_valid    (fetch_valid),
      .flush          (flush),
      .inv_addr       (inv_addr),
      .state          (state),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      start          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      halt_req       = 1'b0;
      rst_n          = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_state"}, 64'(state), 64'h0);
      check_eq({tag, "_pc"}, pc, 64'h0);
      check_eq({tag, "_fv"}, 64'(fetch_valid), 64'h0);
      check_eq({tag, "_flush"}, 64'(flush), 64'h0);
      check_eq({tag, "_inv"}, 64'(inv_addr), 64'h0);
      check_eq({tag, "_cnt"}, 64'(fetch_count), 64'h0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // 1: reset, start, four sequential fetches
      apply_reset();
      check_reset_state("rst1");
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("t1_state_run", 64'(state), 64'h1);
      check_eq("t1_pc0", pc, 64'h0);
      check_eq("t1_fv", 64'(fetch_valid), 64'h1);
      for (int i = 1; i <= 4; i++) begin
         step();
         check_eq("t1_pc", pc, 64'(4 * i));
         check_eq("t1_imem", 64'(imem_addr), 64'(i));
      end
      check_eq("t1_cnt", 64'(fetch_count), 64'h4);

      // 2: stall for three cycles at 0x20
      for (int i = 0; i < 4; i++) step();
      check_eq("t2_pc20", pc, 64'h20);
      check_eq("t2_cnt8", 64'(fetch_count), 64'h8);
      stall = 1'b1;
      #1;
      check_eq("t2_fv_stall", 64'(fetch_valid), 64'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t2_pc_hold", pc, 64'h20);
      end
      check_eq("t2_cnt_hold", 64'(fetch_count), 64'h8);

      // 3: redirect wins over stall; flush is a single-cycle pulse
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      step();
      check_eq("t3_pc", pc, 64'h100);
      check_eq("t3_flush1", 64'(flush), 64'h1);
      check_eq("t3_cnt", 64'(fetch_count), 64'h8);
      redirect_valid = 1'b0;
      stall          = 1'b0;
      step();
      check_eq("t3_pc_seq", pc, 64'h104);
      check_eq("t3_flush0", 64'(flush), 64'h0);
      check_eq("t3_cnt9", 64'(fetch_count), 64'h9);

      // 4: misaligned redirect faults; start afterwards is ignored
      redirect_valid = 1'b1;
      redirect_pc    = 64'h102;
      step();
      redirect_valid = 1'b0;
      check_eq("t4_state", 64'(state), 64'h3);
      check_eq("t4_pc", pc, 64'h102);
      check_eq("t4_inv", 64'(inv_addr), 64'h1);
      check_eq("t4_flush", 64'(flush), 64'h1);
      check_eq("t4_fv", 64'(fetch_valid), 64'h0);
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      check_eq("t4_state_sticky", 64'(state), 64'h3);
      check_eq("t4_pc_frozen", pc, 64'h102);
      check_eq("t4_flush_drop", 64'(flush), 64'h0);
      check_eq("t4_cnt", 64'(fetch_count), 64'hA);

      // 5: sequential step past the last word faults instead of wrapping
      apply_reset();
      check_reset_state("rst5");
      start = 1'b1;
      step();
      start          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFF8;
      step();
      redirect_valid = 1'b0;
      check_eq("t5_pc_ff8", pc, 64'hFF8);
      check_eq("t5_state_run", 64'(state), 64'h1);
      step();
      check_eq("t5_pc_ffc", pc, 64'hFFC);
      check_eq("t5_imem_last", 64'(imem_addr), 64'h3FF);
      check_eq("t5_inv_clear", 64'(inv_addr), 64'h0);
      step();
      check_eq("t5_state", 64'(state), 64'h3);
      check_eq("t5_pc", pc, 64'h1000);
      check_eq("t5_inv", 64'(inv_addr), 64'h1);
      check_eq("t5_flush", 64'(flush), 64'h1);

      // 5b: high address bits must not alias into range
      apply_reset();
      start = 1'b1;
      step();
      start          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0000_0000_0010;
      step();
      redirect_valid = 1'b0;
      check_eq("t5b_state", 64'(state), 64'h3);
      check_eq("t5b_pc", pc, 64'h8000_0000_0000_0010);

      // 6: halt beats redirect; async reset mid-cycle
      apply_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_eq("t6_pc4", pc, 64'h4);
      halt_req       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      step();
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      check_eq("t6_state", 64'(state), 64'h2);
      check_eq("t6_pc", pc, 64'h4);
      check_eq("t6_flush", 64'(flush), 64'h0);
      step();
      check_eq("t6_halt_sticky", 64'(state), 64'h2);
      check_eq("t6_fv", 64'(fetch_valid), 64'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("rst6_async");
      #2;
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
